// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus bundle: instruction memory read port plus the decode valid/stall buffer.
interface fetch_ctrl_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          mem_rvalid;
  logic          stall;
  logic          inst_valid;
  logic [DW-1:0] inst_out;
  logic [AW-1:0] inst_pc;

  modport master (
    output mem_req, mem_addr, inst_valid, inst_out, inst_pc,
    input  mem_rdata, mem_rvalid, stall
  );

  modport slave (
    input  mem_req, mem_addr, inst_valid, inst_out, inst_pc,
    output mem_rdata, mem_rvalid, stall
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller around the external PC register: one read in flight,
// registered instruction buffer toward decode, branch redirect with response drain.
module fetch_ctrl #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int PC_INC = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc_in,
  output logic [AW-1:0] pc_next,
  output logic          pc_wen,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  fetch_ctrl_if.master  bus
);
  typedef enum logic [1:0] {ISSUE, WAIT, DRAIN} state_t;

  state_t        state, state_nxt;
  logic          consume, issue_ok, load, req;
  logic          inst_valid_r;
  logic [DW-1:0] inst_out_r;
  logic [AW-1:0] inst_pc_r;

  assign consume  = inst_valid_r & ~bus.stall;
  assign issue_ok = ~inst_valid_r | consume;

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    load      = 1'b0;
    pc_wen    = 1'b0;
    pc_next   = pc_in;
    case (state)
      ISSUE: begin
        if (issue_ok && !redirect) begin
          req       = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_rvalid && !redirect) begin
          load      = 1'b1;
          pc_wen    = 1'b1;
          pc_next   = pc_in + AW'(PC_INC);
          state_nxt = ISSUE;
        end else if (redirect) begin
          // a response arriving with the redirect is simply dropped
          state_nxt = bus.mem_rvalid ? ISSUE : DRAIN;
        end
      end
      DRAIN: begin
        // the only response still due belongs to the flushed request
        if (bus.mem_rvalid) state_nxt = ISSUE;
      end
      default: state_nxt = ISSUE;
    endcase
    if (redirect) begin
      pc_wen  = 1'b1;
      pc_next = redirect_pc;
    end
    if (rst) begin
      req    = 1'b0;
      pc_wen = 1'b0;
      load   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ISSUE;
      inst_valid_r <= 1'b0;
      inst_out_r   <= '0;
      inst_pc_r    <= '0;
    end else begin
      state <= state_nxt;
      if (redirect) begin
        inst_valid_r <= 1'b0;
      end else if (load) begin
        inst_valid_r <= 1'b1;
        inst_out_r   <= bus.mem_rdata;
        inst_pc_r    <= pc_in;
      end else if (consume) begin
        inst_valid_r <= 1'b0;
      end
    end
  end

  assign bus.mem_req    = req;
  assign bus.mem_addr   = pc_in;
  assign bus.inst_valid = inst_valid_r;
  assign bus.inst_out   = inst_out_r;
  assign bus.inst_pc    = inst_pc_r;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: PC register and latency-programmable memory models, directed
// scenarios, then random stall/redirect traffic checked against an in-order fetch-stream scoreboard.
module tb_fetch_ctrl;
  localparam logic [31:0] K = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_q = '0;
  logic [31:0] pc_rst_val = '0;
  logic [31:0] pc_next;
  logic        pc_wen;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  fetch_ctrl_if #(.AW(32), .DW(32)) bus ();

  fetch_ctrl #(.AW(32), .DW(32), .PC_INC(4)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_q), .pc_next(pc_next), .pc_wen(pc_wen),
    .redirect(redirect), .redirect_pc(redirect_pc), .bus(bus)
  );

  always #5 clk = ~clk;

  // PC register
  always @(posedge clk) begin
    if (rst) pc_q <= pc_rst_val;
    else if (pc_wen) pc_q <= pc_next;
  end

  // memory: response exactly lat cycles after the request, data = addr ^ K
  int          lat = 1;
  int          cnt = 0;
  logic [31:0] pend_addr = '0;
  always @(posedge clk) begin
    if (rst) cnt <= 0;
    else if (bus.mem_req) begin
      cnt       <= lat;
      pend_addr <= bus.mem_addr;
    end else if (cnt != 0) cnt <= cnt - 1;
  end
  assign bus.mem_rvalid = (cnt == 1);
  assign bus.mem_rdata  = pend_addr ^ K;

  int          n_vec = 0, n_err = 0, n_cons = 0;
  logic [31:0] exp_pc = '0;
  logic        o_req, o_wen, o_valid;
  logic [31:0] o_addr, o_next, o_pc, o_out;
  logic        prev_redirect = 1'b0, prev_hold = 1'b0;
  logic [31:0] prev_pc = '0, prev_out = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // one clock: drive inputs, sample at negedge, run scoreboard and protocol checks
  task automatic cyc(input logic st, input logic rd, input logic [31:0] rpc);
    bus.stall   = st;
    redirect    = rd;
    redirect_pc = rpc;
    @(negedge clk);
    o_req   = bus.mem_req;
    o_addr  = bus.mem_addr;
    o_wen   = pc_wen;
    o_next  = pc_next;
    o_valid = bus.inst_valid;
    o_pc    = bus.inst_pc;
    o_out   = bus.inst_out;
    if (rst) begin
      chk("rst_req", 32'(o_req), 32'd0);
      chk("rst_wen", 32'(o_wen), 32'd0);
    end else begin
      if (prev_redirect) chk("flush_after_redirect", 32'(o_valid), 32'd0);
      if (prev_hold) begin
        chk("hold_valid", 32'(o_valid), 32'd1);
        chk("hold_pc", o_pc, prev_pc);
        chk("hold_out", o_out, prev_out);
      end
      if (o_valid && !st) begin
        chk("sb_pc", o_pc, exp_pc);
        chk("sb_data", o_out, exp_pc ^ K);
        exp_pc = exp_pc + 32'd4;
        n_cons++;
      end
      if (rd) begin
        chk("redir_wen", 32'(o_wen), 32'd1);
        chk("redir_next", o_next, rpc);
        exp_pc = rpc;
      end
      if (o_req) begin
        chk("req_addr", o_addr, pc_q);
        chk("one_outstanding", 32'(cnt), 32'd0);
      end
      if (!rd && !bus.mem_rvalid) chk("idle_wen", 32'(o_wen), 32'd0);
    end
    prev_redirect = rd && !rst;
    prev_hold     = o_valid && st && !rd && !rst;
    prev_pc       = o_pc;
    prev_out      = o_out;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b0, 32'd0);
      if (i > 0) begin
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_pc", o_pc, 32'd0);
        chk("rst_out", o_out, 32'd0);
      end
    end
    rst           = 1'b0;
    exp_pc        = pc_rst_val;
    prev_redirect = 1'b0;
    prev_hold     = 1'b0;
  endtask

  initial begin
    logic found;
    int   cons0;
    bus.stall = 1'b0;

    // 1: sequential fetch, L=1, no stall
    lat = 1;
    do_reset(2);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b0, 32'd0);
      chk("t1_req", 32'(o_req), 32'(i % 2 == 0));
      chk("t1_wen", 32'(o_wen), 32'(i % 2 == 1));
      if (i % 2 == 0) chk("t1_addr", o_addr, 32'(4 * (i / 2)));
      if (i >= 2 && i % 2 == 0) chk("t1_ipc", o_pc, 32'(4 * (i / 2 - 1)));
    end

    // 2: stall holds the buffer, release issues next PC in the same cycle
    do_reset(2);
    cyc(1'b0, 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 32'd0);
      chk("t2_req", 32'(o_req), 32'd0);
      chk("t2_wen", 32'(o_wen), 32'd0);
      chk("t2_valid", 32'(o_valid), 32'd1);
      chk("t2_pc", o_pc, 32'd0);
      chk("t2_out", o_out, K);
    end
    cyc(1'b0, 1'b0, 32'd0);
    chk("t2_rel_req", 32'(o_req), 32'd1);
    chk("t2_rel_addr", o_addr, 32'd4);

    // 3: L=3, redirect one cycle after the request -> drain
    lat = 3;
    do_reset(2);
    cyc(1'b0, 1'b0, 32'd0);
    chk("t3_req0", 32'(o_req), 32'd1);
    cyc(1'b0, 1'b1, 32'h100);
    chk("t3_req1", 32'(o_req), 32'd0);
    cyc(1'b0, 1'b0, 32'd0);
    chk("t3_req2", 32'(o_req), 32'd0);
    cyc(1'b0, 1'b0, 32'd0);
    chk("t3_req3", 32'(o_req), 32'd0);
    chk("t3_valid3", 32'(o_valid), 32'd0);
    chk("t3_wen3", 32'(o_wen), 32'd0);
    cyc(1'b0, 1'b0, 32'd0);
    chk("t3_req4", 32'(o_req), 32'd1);
    chk("t3_addr4", o_addr, 32'h100);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc(1'b0, 1'b0, 32'd0);
      if (o_valid) found = 1'b1;
    end
    chk("t3_arrive", 32'(found), 32'd1);
    chk("t3_ipc", o_pc, 32'h100);
    chk("t3_iout", o_out, 32'h100 ^ K);

    // 4: redirect in the same cycle as the response
    lat = 2;
    do_reset(2);
    cyc(1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b1, 32'h200);
    chk("t4_wen", 32'(o_wen), 32'd1);
    chk("t4_next", o_next, 32'h200);
    cyc(1'b0, 1'b0, 32'd0);
    chk("t4_valid", 32'(o_valid), 32'd0);
    chk("t4_req", 32'(o_req), 32'd1);
    chk("t4_addr", o_addr, 32'h200);

    // 5: PC wrap
    lat = 1;
    do_reset(2);
    cyc(1'b0, 1'b1, 32'hFFFF_FFFC);
    chk("t5_noreq", 32'(o_req), 32'd0);
    cyc(1'b0, 1'b0, 32'd0);
    chk("t5_addr", o_addr, 32'hFFFF_FFFC);
    cyc(1'b0, 1'b0, 32'd0);
    chk("t5_wen", 32'(o_wen), 32'd1);
    chk("t5_next", o_next, 32'd0);
    cyc(1'b0, 1'b0, 32'd0);
    chk("t5_ipc", o_pc, 32'hFFFF_FFFC);
    chk("t5_addr2", o_addr, 32'd0);

    // 6: reset while waiting for a response
    lat = 2;
    do_reset(2);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 32'd0);
    chk("t6_req_wait", 32'(o_req), 32'd1);
    chk("t6_addr_wait", o_addr, 32'd4);
    pc_rst_val = 32'h40;
    do_reset(2);
    cyc(1'b0, 1'b0, 32'd0);
    chk("t6_req_after", 32'(o_req), 32'd1);
    chk("t6_addr_after", o_addr, 32'h40);

    // random stall / redirect / latency traffic
    pc_rst_val = 32'h0;
    do_reset(2);
    cons0 = n_cons;
    for (int i = 0; i < 500; i++) begin
      lat = int'($urandom_range(1, 4));
      cyc($urandom_range(0, 9) < 3, $urandom_range(0, 24) == 0, $urandom() & 32'hFFFF_FFFC);
    end
    chk("rand_liveness", 32'(n_cons - cons0 > 25), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
